// File: rtl/sirv_icb2_rr_arbiter.sv
// sirv_icb2_rr_arbiter
// 2:1 ICB arbiter sharing one bridge command/response port between master 0 (CPU) and
// master 1 (display/DMA). Commands pass through with zero latency. A granted command that
// stalls locks the grant until it is accepted. An in-order ID FIFO routes each response
// back to the master that issued the command.
// Optional macro ICB_ARB_RR_EN: when defined, contested grants alternate round-robin;
// when undefined, master 0 has fixed priority.
module sirv_icb2_rr_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned OUTS_NUM = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,

  // Master 0 (CPU)
  input  logic          i_m0_icb_cmd_valid,
  output logic          o_m0_icb_cmd_ready,
  input  logic          i_m0_icb_cmd_read,
  input  logic [AW-1:0] i_m0_icb_cmd_addr,
  input  logic [31:0]   i_m0_icb_cmd_wdata,
  input  logic [3:0]    i_m0_icb_cmd_wmask,
  input  logic [1:0]    i_m0_icb_cmd_size,
  output logic          o_m0_icb_rsp_valid,
  input  logic          i_m0_icb_rsp_ready,
  output logic          o_m0_icb_rsp_err,
  output logic [31:0]   o_m0_icb_rsp_rdata,

  // Master 1 (display/DMA)
  input  logic          i_m1_icb_cmd_valid,
  output logic          o_m1_icb_cmd_ready,
  input  logic          i_m1_icb_cmd_read,
  input  logic [AW-1:0] i_m1_icb_cmd_addr,
  input  logic [31:0]   i_m1_icb_cmd_wdata,
  input  logic [3:0]    i_m1_icb_cmd_wmask,
  input  logic [1:0]    i_m1_icb_cmd_size,
  output logic          o_m1_icb_rsp_valid,
  input  logic          i_m1_icb_rsp_ready,
  output logic          o_m1_icb_rsp_err,
  output logic [31:0]   o_m1_icb_rsp_rdata,

  // Shared bridge port
  output logic          o_s_icb_cmd_valid,
  input  logic          i_s_icb_cmd_ready,
  output logic          o_s_icb_cmd_read,
  output logic [AW-1:0] o_s_icb_cmd_addr,
  output logic [31:0]   o_s_icb_cmd_wdata,
  output logic [3:0]    o_s_icb_cmd_wmask,
  output logic [1:0]    o_s_icb_cmd_size,
  input  logic          i_s_icb_rsp_valid,
  output logic          o_s_icb_rsp_ready,
  input  logic          i_s_icb_rsp_err,
  input  logic [31:0]   i_s_icb_rsp_rdata
);

  localparam int unsigned PtrW = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
  localparam int unsigned CntW = $clog2(OUTS_NUM + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(OUTS_NUM);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(OUTS_NUM - 1);

  // Arbitration state
  logic            r_lock;
  logic            r_lock_id;
  logic            r_last_id;

  // Outstanding-ID FIFO
  logic            r_fifo [OUTS_NUM];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_cnt;

  logic            w_grant;
  logic            w_gnt_valid;
  logic            w_not_full;
  logic            w_not_empty;
  logic            w_cmd_hs;
  logic            w_rsp_hs;
  logic            w_head;
  logic            w_head_ready;
  logic            w_push;
  logic            w_pop;

  // Wrap-around pointer increment for a FIFO depth that need not be a power of two
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Full/empty derive from the registered count only, so cmd_ready never depends on rsp
  assign w_not_full  = (r_cnt != CntFull);
  assign w_not_empty = (r_cnt != '0);

  // Grant selection: a locked grant wins, otherwise the configured arbitration rule
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_lock_id;
`ifdef ICB_ARB_RR_EN
    end else if (i_m0_icb_cmd_valid && i_m1_icb_cmd_valid) begin
      w_grant = ~r_last_id;
`endif
    end else if (i_m0_icb_cmd_valid) begin
      w_grant = 1'b0;
    end else if (i_m1_icb_cmd_valid) begin
      w_grant = 1'b1;
    end else begin
      // Idle: point at the master that did not go last; no command is presented anyway
      w_grant = ~r_last_id;
    end
  end

  // Command multiplexer towards the bridge
  always_comb begin
    if (w_grant) begin
      w_gnt_valid       = i_m1_icb_cmd_valid;
      o_s_icb_cmd_read  = i_m1_icb_cmd_read;
      o_s_icb_cmd_addr  = i_m1_icb_cmd_addr;
      o_s_icb_cmd_wdata = i_m1_icb_cmd_wdata;
      o_s_icb_cmd_wmask = i_m1_icb_cmd_wmask;
      o_s_icb_cmd_size  = i_m1_icb_cmd_size;
    end else begin
      w_gnt_valid       = i_m0_icb_cmd_valid;
      o_s_icb_cmd_read  = i_m0_icb_cmd_read;
      o_s_icb_cmd_addr  = i_m0_icb_cmd_addr;
      o_s_icb_cmd_wdata = i_m0_icb_cmd_wdata;
      o_s_icb_cmd_wmask = i_m0_icb_cmd_wmask;
      o_s_icb_cmd_size  = i_m0_icb_cmd_size;
    end
  end

  assign o_s_icb_cmd_valid  = w_gnt_valid & w_not_full;
  assign o_m0_icb_cmd_ready = ~w_grant & i_s_icb_cmd_ready & w_not_full;
  assign o_m1_icb_cmd_ready =  w_grant & i_s_icb_cmd_ready & w_not_full;
  assign w_cmd_hs           = o_s_icb_cmd_valid & i_s_icb_cmd_ready;

  // Response routing by the oldest outstanding ID
  assign w_head       = r_fifo[r_rptr];
  assign w_head_ready = w_head ? i_m1_icb_rsp_ready : i_m0_icb_rsp_ready;

  assign o_m0_icb_rsp_valid = i_s_icb_rsp_valid & w_not_empty & ~w_head;
  assign o_m1_icb_rsp_valid = i_s_icb_rsp_valid & w_not_empty &  w_head;
  assign o_s_icb_rsp_ready  = w_head_ready & w_not_empty;
  assign w_rsp_hs           = i_s_icb_rsp_valid & o_s_icb_rsp_ready;

  // Response payload is broadcast; only the valid qualifies the receiver
  assign o_m0_icb_rsp_err   = i_s_icb_rsp_err;
  assign o_m0_icb_rsp_rdata = i_s_icb_rsp_rdata;
  assign o_m1_icb_rsp_err   = i_s_icb_rsp_err;
  assign o_m1_icb_rsp_rdata = i_s_icb_rsp_rdata;

  // w_cmd_hs already implies the FIFO is not full, so a same-cycle pop never frees a slot early
  assign w_push = w_cmd_hs;
  assign w_pop  = w_rsp_hs;

  // Lock the grant while a presented command is stalled; release on acceptance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (o_s_icb_cmd_valid && !i_s_icb_cmd_ready) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_grant;
    end else if (w_cmd_hs) begin
      r_lock    <= 1'b0;
    end
  end

  // Remember who was served last; reset value 1 lets master 0 win the first contest
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_id <= 1'b1;
    end else if (w_cmd_hs) begin
      r_last_id <= w_grant;
    end
  end

  // ID storage; contents are don't-care once the pointers are reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_grant;
    end
  end

  // FIFO write pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= ptr_inc(r_wptr);
    end
  end

  // FIFO read pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= ptr_inc(r_rptr);
    end
  end

  // Outstanding count; simultaneous push and pop leave it unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (!w_push && w_pop) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

endmodule

// File: tb/tb_sirv_icb2_rr_arbiter.sv
// Randomized scoreboard bench for sirv_icb2_rr_arbiter. The reference model keeps the
// outstanding master IDs in a queue and the stalled master (if any) in an int; expected
// responses are queued at command acceptance and popped by an independent monitor.
module tb_sirv_icb2_rr_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned OUTS = 4;

  typedef struct packed {
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
  } cmd_t;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus
  logic        mv [2];
  cmd_t        mc [2];
  logic        rr [2];
  logic        s_ready;
  logic        s_rsp_valid;
  logic        s_rsp_err;
  logic [31:0] s_rsp_rdata;

  // DUT outputs
  logic          m0_cmd_ready, m1_cmd_ready;
  logic          m0_rsp_valid, m1_rsp_valid;
  logic          m0_rsp_err, m1_rsp_err;
  logic [31:0]   m0_rsp_rdata, m1_rsp_rdata;
  logic          s_cmd_valid, s_cmd_read;
  logic [AW-1:0] s_cmd_addr;
  logic [31:0]   s_cmd_wdata;
  logic [3:0]    s_cmd_wmask;
  logic [1:0]    s_cmd_size;
  logic          s_rsp_ready;

  sirv_icb2_rr_arbiter #(.AW(AW), .OUTS_NUM(OUTS)) u_dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_m0_icb_cmd_valid (mv[0]),
    .o_m0_icb_cmd_ready (m0_cmd_ready),
    .i_m0_icb_cmd_read  (mc[0].read),
    .i_m0_icb_cmd_addr  (mc[0].addr),
    .i_m0_icb_cmd_wdata (mc[0].wdata),
    .i_m0_icb_cmd_wmask (mc[0].wmask),
    .i_m0_icb_cmd_size  (mc[0].size),
    .o_m0_icb_rsp_valid (m0_rsp_valid),
    .i_m0_icb_rsp_ready (rr[0]),
    .o_m0_icb_rsp_err   (m0_rsp_err),
    .o_m0_icb_rsp_rdata (m0_rsp_rdata),
    .i_m1_icb_cmd_valid (mv[1]),
    .o_m1_icb_cmd_ready (m1_cmd_ready),
    .i_m1_icb_cmd_read  (mc[1].read),
    .i_m1_icb_cmd_addr  (mc[1].addr),
    .i_m1_icb_cmd_wdata (mc[1].wdata),
    .i_m1_icb_cmd_wmask (mc[1].wmask),
    .i_m1_icb_cmd_size  (mc[1].size),
    .o_m1_icb_rsp_valid (m1_rsp_valid),
    .i_m1_icb_rsp_ready (rr[1]),
    .o_m1_icb_rsp_err   (m1_rsp_err),
    .o_m1_icb_rsp_rdata (m1_rsp_rdata),
    .o_s_icb_cmd_valid  (s_cmd_valid),
    .i_s_icb_cmd_ready  (s_ready),
    .o_s_icb_cmd_read   (s_cmd_read),
    .o_s_icb_cmd_addr   (s_cmd_addr),
    .o_s_icb_cmd_wdata  (s_cmd_wdata),
    .o_s_icb_cmd_wmask  (s_cmd_wmask),
    .o_s_icb_cmd_size   (s_cmd_size),
    .i_s_icb_rsp_valid  (s_rsp_valid),
    .o_s_icb_rsp_ready  (s_rsp_ready),
    .i_s_icb_rsp_err    (s_rsp_err),
    .i_s_icb_rsp_rdata  (s_rsp_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int   ids [$];   // masters with outstanding commands, oldest first
  int   pend;      // master whose presented command stalled, -1 if none
  int   last;      // master served by the most recent acceptance
  rsp_t exp_q [$]; // scoreboard: responses the masters must receive, in order
  rsp_t brg_q [$]; // responses the bridge model still owes

  // Knobs (percent) and handshake flags captured at the sample point
  int   p_valid, p_sready, p_rvalid, p_bogus, p_rready;
  bit   hold;
  bit   d_m_hs [2];
  bit   d_s_rsp_hs;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t rand_cmd(input int k);
    cmd_t c;
    c.read  = 1'($urandom_range(0, 1));
    c.addr  = (k == 0 ? 32'h1000_0000 : 32'h2000_0000) | ($urandom & 32'h00ff_fffc);
    c.wdata = $urandom;
    c.wmask = 4'($urandom);
    c.size  = 2'($urandom);
    return c;
  endfunction

  function automatic cmd_t fixed_cmd(input int k);
    cmd_t c;
    c.read  = 1'b1;
    c.addr  = (k == 0) ? 32'h0000_1000 : 32'h0000_2000;
    c.wdata = 32'h0;
    c.wmask = 4'h0;
    c.size  = 2'd2;
    return c;
  endfunction

  // Who should own the bridge this cycle, from the arbitration rules alone
  function automatic int model_grant(input logic v0, input logic v1);
    if (pend >= 0) return pend;
`ifdef ICB_ARB_RR_EN
    if (v0 && v1) return 1 - last;
`endif
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Compare DUT outputs against the model at the sample point, then advance the model
  task automatic eval();
    int          g;
    int          head;
    bit          full, ne, exp_sv, cmd_hs, rsp_hs;
    cmd_t        act_c;
    logic [31:0] rd;
    logic        er;
    g      = model_grant(mv[0], mv[1]);
    full   = (ids.size() >= int'(OUTS));
    exp_sv = (g >= 0) && mv[g] && !full;
    check("s_cmd_valid", 128'(s_cmd_valid), 128'(exp_sv));
    if (g >= 0) begin
      check("cmd_ready_granted", 128'(g == 1 ? m1_cmd_ready : m0_cmd_ready),
            128'(s_ready && !full));
      check("cmd_ready_other", 128'(g == 1 ? m0_cmd_ready : m1_cmd_ready), 128'(0));
    end
    if (exp_sv) begin
      act_c = {s_cmd_read, s_cmd_addr, s_cmd_wdata, s_cmd_wmask, s_cmd_size};
      check("s_cmd_fields", 128'(act_c), 128'(mc[g]));
    end
    ne   = (ids.size() > 0);
    head = ne ? ids[0] : 0;
    check("rsp_valid_m0", 128'(m0_rsp_valid), 128'(ne && head == 0 && s_rsp_valid));
    check("rsp_valid_m1", 128'(m1_rsp_valid), 128'(ne && head == 1 && s_rsp_valid));
    check("s_rsp_ready", 128'(s_rsp_ready), 128'(ne && rr[head]));

    // Bridge payload decided once, shared by the bridge model and the scoreboard
    rd = $urandom;
    er = ($urandom_range(0, 3) == 0);
    if (s_cmd_valid && s_ready) brg_q.push_back({1'b0, er, rd});
    d_m_hs[0]  = mv[0] && m0_cmd_ready;
    d_m_hs[1]  = mv[1] && m1_cmd_ready;
    d_s_rsp_hs = s_rsp_valid && s_rsp_ready;

    cmd_hs = exp_sv && s_ready;
    rsp_hs = ne && s_rsp_valid && rr[head];
    if (exp_sv && !s_ready) pend = g;
    else if (cmd_hs) begin
      pend = -1;
      last = g;
    end
    if (rsp_hs) void'(ids.pop_front());
    if (cmd_hs) begin
      ids.push_back(g);
      exp_q.push_back({1'(g), er, rd});
    end
  endtask

  // Drive the next cycle's stimulus (called just after the active edge)
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (!hold && (d_m_hs[k] || !mv[k])) begin
        mv[k] = ($urandom_range(0, 99) < p_valid);
        mc[k] = rand_cmd(k);
      end
      rr[k] = ($urandom_range(0, 99) < p_rready);
    end
    s_ready = ($urandom_range(0, 99) < p_sready);
    if (d_s_rsp_hs) begin
      if (brg_q.size() > 0) void'(brg_q.pop_front());
      s_rsp_valid = 1'b0;
    end
    if (brg_q.size() == 0) s_rsp_valid = ($urandom_range(0, 99) < p_bogus);
    else if (!s_rsp_valid) s_rsp_valid = ($urandom_range(0, 99) < p_rvalid);
    if (brg_q.size() > 0) begin
      s_rsp_err   = brg_q[0].err;
      s_rsp_rdata = brg_q[0].rdata;
    end else begin
      s_rsp_err   = 1'b1;
      s_rsp_rdata = 32'hbad0_0bad;
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    drive();
  endtask

  // One-cycle reset, then a contested cycle that must go to master 0 with nothing routable
  task automatic do_reset();
    rst = 1'b1;
    mv[0] = 1'b0; mv[1] = 1'b0;
    s_ready = 1'b0;
    s_rsp_valid = 1'b1; s_rsp_err = 1'b1; s_rsp_rdata = 32'hbad0_0bad;
    rr[0] = 1'b1; rr[1] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ids.delete(); exp_q.delete(); brg_q.delete();
    pend = -1; last = 1;
    mv[0] = 1'b1; mc[0] = fixed_cmd(0);
    mv[1] = 1'b1; mc[1] = fixed_cmd(1);
    s_ready = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 128'({m0_rsp_valid, m1_rsp_valid}), 128'(0));
    check("rst_s_rsp_ready", 128'(s_rsp_ready), 128'(0));
    check("rst_first_grant", 128'(s_cmd_addr), 128'(32'h0000_1000));
    eval();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic mon_take(input int k, input logic err, input logic [31:0] rdata);
    rsp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_unexpected: master %0d got rsp 0x%0h, expected none", k, rdata);
    end else begin
      e = exp_q.pop_front();
      check("rsp_master", 128'(k), 128'(e.id));
      check("rsp_err", 128'(err), 128'(e.err));
      check("rsp_rdata", 128'(rdata), 128'(e.rdata));
    end
  endtask

  // Monitor: every response delivered to a master is matched against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m0_rsp_valid && rr[0]) mon_take(0, m0_rsp_err, m0_rsp_rdata);
      if (m1_rsp_valid && rr[1]) mon_take(1, m1_rsp_err, m1_rsp_rdata);
    end
  end

  task automatic set_knobs(input int v, input int sr, input int rv, input int bg,
                           input int rdy);
    p_valid = v; p_sready = sr; p_rvalid = rv; p_bogus = bg; p_rready = rdy;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    pend = -1; last = 1;
    d_m_hs[0] = 1'b0; d_m_hs[1] = 1'b0; d_s_rsp_hs = 1'b0;
    mc[0] = fixed_cmd(0); mc[1] = fixed_cmd(1);

    // Both masters hold reads, bridge always ready, no responses: fills the FIFO
    hold = 1'b1;
    set_knobs(100, 100, 0, 0, 100);
    do_reset();
    repeat (5) step();
    // Responses enabled: the stalled command goes next; sustained push/pop wraps pointers
    set_knobs(100, 100, 100, 0, 100);
    repeat (12) step();

    // Stall the bridge while both keep requesting; lock must hold the granted master
    set_knobs(100, 0, 100, 0, 100);
    repeat (3) step();
    set_knobs(100, 100, 100, 0, 100);
    repeat (4) step();

    hold = 1'b0;
    set_knobs(60, 70, 60, 10, 70);
    repeat (1500) step();
    set_knobs(90, 90, 15, 10, 60);
    repeat (600) step();

    // Reset with at least three commands outstanding
    set_knobs(90, 90, 0, 0, 100);
    guard = 0;
    while (ids.size() < 3 && guard < 200) begin
      step();
      guard++;
    end
    check("pre_reset_outstanding", 128'(ids.size() >= 3), 128'(1));
    do_reset();

    set_knobs(80, 85, 80, 5, 85);
    repeat (800) step();

    // Drain everything still in flight
    set_knobs(0, 100, 100, 0, 100);
    repeat (40) step();
    check("drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
